// File: rtl/clock_sweep_controller.sv
// clock_sweep_controller
//   Drives the clock-period characterisation sweep. It first checks MAX_PERIOD
//   as a sanity trial. It then binary-searches [MIN_PERIOD, MAX_PERIOD] for the
//   smallest period that passes, taking one pass/fail verdict per trial edge.
// Ports
//   clock_finished  in   one rising edge per completed trial
//   sys_reset       in   asynchronous, active-high reset
//   start           in   level, begins a sweep from IDLE or DONE
//   abort           in   level, forces IDLE with reset values on the next edge
//   trial_pass      in   verdict of the trial that just ended
//   current_period  out  period the clock generator uses for the next trial
//   best_period     out  smallest period proven passing (0 = none)
//   busy            out  sweep in progress (VERIFY or SEARCH)
//   sweep_done      out  sweep finished
//   sweep_failed    out  sweep finished because MAX_PERIOD failed
//   trial_count     out  verdicts consumed this sweep, saturating
module clock_sweep_controller #(
  parameter int unsigned PERIOD_WIDTH = 32,
  parameter int unsigned MIN_PERIOD   = 1,
  parameter int unsigned MAX_PERIOD   = 100,
  parameter int unsigned COUNT_WIDTH  = 8
) (
  input  logic                    clock_finished,
  input  logic                    sys_reset,
  input  logic                    start,
  input  logic                    abort,
  input  logic                    trial_pass,
  output logic [PERIOD_WIDTH-1:0] current_period,
  output logic [PERIOD_WIDTH-1:0] best_period,
  output logic                    busy,
  output logic                    sweep_done,
  output logic                    sweep_failed,
  output logic [COUNT_WIDTH-1:0]  trial_count
);

  typedef enum logic [1:0] {IDLE, VERIFY, SEARCH, DONE} state_t;

  localparam logic [PERIOD_WIDTH-1:0] MIN_P = PERIOD_WIDTH'(MIN_PERIOD);
  localparam logic [PERIOD_WIDTH-1:0] MAX_P = PERIOD_WIDTH'(MAX_PERIOD);
  localparam logic [PERIOD_WIDTH-1:0] ONE_P = PERIOD_WIDTH'(1);
  localparam logic [COUNT_WIDTH-1:0]  ONE_C = COUNT_WIDTH'(1);

  state_t                  state_q, state_d;
  logic [PERIOD_WIDTH-1:0] lo_q, lo_d;
  logic [PERIOD_WIDTH-1:0] hi_q, hi_d;
  logic [PERIOD_WIDTH-1:0] cur_q, cur_d;
  logic [PERIOD_WIDTH-1:0] best_q, best_d;
  logic [COUNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                    failed_q, failed_d;
  logic [COUNT_WIDTH-1:0]  cnt_inc;

  // Midpoint uses one extra bit for the sum, so it cannot wrap at the top of range.
  function automatic logic [PERIOD_WIDTH-1:0] mid_of(input logic [PERIOD_WIDTH-1:0] a,
                                                     input logic [PERIOD_WIDTH-1:0] b);
    logic [PERIOD_WIDTH:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[PERIOD_WIDTH:1];
  endfunction

  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + ONE_C;

  always_ff @(posedge clock_finished or posedge sys_reset) begin
    if (sys_reset) begin
      state_q  <= IDLE;
      lo_q     <= MIN_P;
      hi_q     <= MAX_P;
      cur_q    <= MAX_P;
      best_q   <= '0;
      cnt_q    <= '0;
      failed_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      lo_q     <= lo_d;
      hi_q     <= hi_d;
      cur_q    <= cur_d;
      best_q   <= best_d;
      cnt_q    <= cnt_d;
      failed_q <= failed_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    lo_d     = lo_q;
    hi_d     = hi_q;
    cur_d    = cur_q;
    best_d   = best_q;
    cnt_d    = cnt_q;
    failed_d = failed_q;
    if (abort) begin
      state_d  = IDLE;
      lo_d     = MIN_P;
      hi_d     = MAX_P;
      cur_d    = MAX_P;
      best_d   = '0;
      cnt_d    = '0;
      failed_d = 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_d  = VERIFY;
            lo_d     = MIN_P;
            hi_d     = MAX_P;
            cur_d    = MAX_P;
            best_d   = '0;
            cnt_d    = '0;
            failed_d = 1'b0;
          end
        end
        VERIFY: begin
          cnt_d = cnt_inc;
          if (!trial_pass) begin
            state_d  = DONE;
            failed_d = 1'b1;
            best_d   = '0;
          end else begin
            best_d = MAX_P;
            hi_d   = MAX_P;
            lo_d   = MIN_P;
            if (MIN_P == MAX_P) begin
              state_d = DONE;
            end else begin
              state_d = SEARCH;
              cur_d   = mid_of(MIN_P, MAX_P);
            end
          end
        end
        SEARCH: begin
          cnt_d = cnt_inc;
          if (trial_pass) begin
            hi_d   = cur_q;
            best_d = cur_q;
          end else begin
            lo_d = cur_q + ONE_P;
          end
          // The interval bounds just computed decide whether another trial is needed.
          if (lo_d == hi_d) begin
            state_d = DONE;
          end else begin
            cur_d = mid_of(lo_d, hi_d);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign current_period = cur_q;
  assign best_period    = best_q;
  assign busy           = (state_q == VERIFY) || (state_q == SEARCH);
  assign sweep_done     = (state_q == DONE);
  assign sweep_failed   = failed_q;
  assign trial_count    = cnt_q;

endmodule

// File: tb/tb_clock_sweep_controller.sv
module tb_clock_sweep_controller;

  logic clk = 1'b0;
  logic sys_reset;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  // Default instance: 1..100
  logic        d_start, d_abort, d_pass, d_busy, d_done, d_failed;
  logic [31:0] d_cur, d_best;
  logic [7:0]  d_cnt;

  clock_sweep_controller u_def (
    .clock_finished(clk), .sys_reset(sys_reset), .start(d_start), .abort(d_abort),
    .trial_pass(d_pass), .current_period(d_cur), .best_period(d_best), .busy(d_busy),
    .sweep_done(d_done), .sweep_failed(d_failed), .trial_count(d_cnt)
  );

  // Degenerate range instance: 20..20
  logic        o_start, o_abort, o_pass, o_busy, o_done, o_failed;
  logic [31:0] o_cur, o_best;
  logic [7:0]  o_cnt;

  clock_sweep_controller #(.MIN_PERIOD(20), .MAX_PERIOD(20)) u_one (
    .clock_finished(clk), .sys_reset(sys_reset), .start(o_start), .abort(o_abort),
    .trial_pass(o_pass), .current_period(o_cur), .best_period(o_best), .busy(o_busy),
    .sweep_done(o_done), .sweep_failed(o_failed), .trial_count(o_cnt)
  );

  // Top-of-range instance: 8-bit, 254..255
  logic       w_start, w_abort, w_pass, w_busy, w_done, w_failed;
  logic [7:0] w_cur, w_best;
  logic [7:0] w_cnt;

  clock_sweep_controller #(.PERIOD_WIDTH(8), .MIN_PERIOD(254), .MAX_PERIOD(255)) u_w8 (
    .clock_finished(clk), .sys_reset(sys_reset), .start(w_start), .abort(w_abort),
    .trial_pass(w_pass), .current_period(w_cur), .best_period(w_best), .busy(w_busy),
    .sweep_done(w_done), .sweep_failed(w_failed), .trial_count(w_cnt)
  );

  int unsigned exp37[8]  = '{100, 50, 25, 38, 32, 35, 37, 36};
  int unsigned expall[8] = '{100, 50, 25, 13, 7, 4, 2, 1};

  task automatic arm_def();
    @(negedge clk); d_start = 1'b1;
    @(posedge clk); #1; d_start = 1'b0;
  endtask

  // The stimulus plays a DUT that passes iff the period is at least thr.
  task automatic trial_def(input int unsigned thr);
    @(negedge clk); d_pass = (d_cur >= thr);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    sys_reset = 1'b1;
    #2;
    n_cmp++; if (d_cur !== 100) begin n_bad++; $display("FAIL rst_cur: got %0d want 100", d_cur); end
    n_cmp++; if (d_best !== 0) begin n_bad++; $display("FAIL rst_best: got %0d want 0", d_best); end
    n_cmp++; if (d_cnt !== 0) begin n_bad++; $display("FAIL rst_cnt: got %0d want 0", d_cnt); end
    n_cmp++; if ({d_busy, d_done, d_failed} !== 3'b000) begin n_bad++; $display("FAIL rst_flags: got %b want 000", {d_busy, d_done, d_failed}); end
    n_cmp++; if (w_cur !== 255) begin n_bad++; $display("FAIL rst_w8_cur: got %0d want 255", w_cur); end
    @(negedge clk); sys_reset = 1'b0;
    // Idle edge with a pass verdict: nothing must be consumed.
    d_pass = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (d_cnt !== 0 || d_busy !== 1'b0) begin n_bad++; $display("FAIL idle_ignore: got cnt=%0d busy=%b want 0/0", d_cnt, d_busy); end
  endtask

  task automatic test_search_37();
    arm_def();
    n_cmp++; if (d_busy !== 1'b1 || d_cnt !== 0 || d_best !== 0) begin n_bad++; $display("FAIL s37_arm: got busy=%b cnt=%0d best=%0d want 1/0/0", d_busy, d_cnt, d_best); end
    for (int i = 0; i < 8; i++) begin
      n_cmp++; if (d_cur !== exp37[i]) begin n_bad++; $display("FAIL s37_period[%0d]: got %0d want %0d", i, d_cur, exp37[i]); end
      trial_def(37);
    end
    n_cmp++; if (d_done !== 1'b1 || d_busy !== 1'b0) begin n_bad++; $display("FAIL s37_done: got done=%b busy=%b want 1/0", d_done, d_busy); end
    n_cmp++; if (d_best !== 37) begin n_bad++; $display("FAIL s37_best: got %0d want 37", d_best); end
    n_cmp++; if (d_cnt !== 8) begin n_bad++; $display("FAIL s37_cnt: got %0d want 8", d_cnt); end
    n_cmp++; if (d_failed !== 1'b0) begin n_bad++; $display("FAIL s37_failed: got %b want 0", d_failed); end
  endtask

  task automatic test_done_hold();
    @(negedge clk); d_pass = ~d_pass;
    @(posedge clk); #1;
    n_cmp++; if (d_done !== 1'b1 || d_best !== 37 || d_cnt !== 8) begin n_bad++; $display("FAIL hold: got done=%b best=%0d cnt=%0d want 1/37/8", d_done, d_best, d_cnt); end
  endtask

  task automatic test_verify_fail();
    arm_def();
    n_cmp++; if (d_best !== 0 || d_cnt !== 0 || d_cur !== 100) begin n_bad++; $display("FAIL vf_rearm: got best=%0d cnt=%0d cur=%0d want 0/0/100", d_best, d_cnt, d_cur); end
    trial_def(101);
    n_cmp++; if (d_done !== 1'b1 || d_failed !== 1'b1) begin n_bad++; $display("FAIL vf_flags: got done=%b failed=%b want 1/1", d_done, d_failed); end
    n_cmp++; if (d_best !== 0 || d_cnt !== 1) begin n_bad++; $display("FAIL vf_result: got best=%0d cnt=%0d want 0/1", d_best, d_cnt); end
  endtask

  task automatic test_all_pass();
    arm_def();
    n_cmp++; if (d_failed !== 1'b0) begin n_bad++; $display("FAIL ap_failed_clear: got %b want 0", d_failed); end
    for (int i = 0; i < 8; i++) begin
      n_cmp++; if (d_cur !== expall[i]) begin n_bad++; $display("FAIL ap_period[%0d]: got %0d want %0d", i, d_cur, expall[i]); end
      trial_def(0);
    end
    n_cmp++; if (d_done !== 1'b1 || d_best !== 1 || d_cnt !== 8) begin n_bad++; $display("FAIL ap_result: got done=%b best=%0d cnt=%0d want 1/1/8", d_done, d_best, d_cnt); end
  endtask

  task automatic test_single_point();
    @(negedge clk); o_start = 1'b1;
    @(posedge clk); #1; o_start = 1'b0;
    n_cmp++; if (o_cur !== 20 || o_busy !== 1'b1) begin n_bad++; $display("FAIL sp_arm: got cur=%0d busy=%b want 20/1", o_cur, o_busy); end
    @(negedge clk); o_pass = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (o_done !== 1'b1 || o_busy !== 1'b0) begin n_bad++; $display("FAIL sp_done: got done=%b busy=%b want 1/0", o_done, o_busy); end
    n_cmp++; if (o_best !== 20 || o_cnt !== 1 || o_failed !== 1'b0) begin n_bad++; $display("FAIL sp_result: got best=%0d cnt=%0d failed=%b want 20/1/0", o_best, o_cnt, o_failed); end
  endtask

  task automatic test_top_of_range();
    @(negedge clk); w_start = 1'b1;
    @(posedge clk); #1; w_start = 1'b0;
    n_cmp++; if (w_cur !== 255) begin n_bad++; $display("FAIL tr_p0: got %0d want 255", w_cur); end
    @(negedge clk); w_pass = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (w_cur !== 254 || w_busy !== 1'b1) begin n_bad++; $display("FAIL tr_mid: got cur=%0d busy=%b want 254/1", w_cur, w_busy); end
    @(negedge clk); w_pass = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (w_done !== 1'b1 || w_best !== 255 || w_cnt !== 2 || w_failed !== 1'b0) begin n_bad++; $display("FAIL tr_result: got done=%b best=%0d cnt=%0d failed=%b want 1/255/2/0", w_done, w_best, w_cnt, w_failed); end
  endtask

  task automatic test_reset_midsweep();
    arm_def();
    for (int i = 0; i < 3; i++) trial_def(37);
    n_cmp++; if (d_cnt !== 3 || d_cur !== 38 || d_best !== 50) begin n_bad++; $display("FAIL rm_pre: got cnt=%0d cur=%0d best=%0d want 3/38/50", d_cnt, d_cur, d_best); end
    #2; sys_reset = 1'b1; #1;
    n_cmp++; if (d_cur !== 100 || d_best !== 0 || d_cnt !== 0) begin n_bad++; $display("FAIL rm_vals: got cur=%0d best=%0d cnt=%0d want 100/0/0", d_cur, d_best, d_cnt); end
    n_cmp++; if ({d_busy, d_done, d_failed} !== 3'b000) begin n_bad++; $display("FAIL rm_flags: got %b want 000", {d_busy, d_done, d_failed}); end
    @(negedge clk); sys_reset = 1'b0;
    test_search_37();
  endtask

  task automatic test_abort();
    arm_def();
    for (int i = 0; i < 3; i++) trial_def(37);
    @(negedge clk); d_abort = 1'b1; d_start = 1'b1; d_pass = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (d_busy !== 1'b0 || d_done !== 1'b0) begin n_bad++; $display("FAIL ab_state: got busy=%b done=%b want 0/0", d_busy, d_done); end
    n_cmp++; if (d_cur !== 100 || d_best !== 0 || d_cnt !== 0) begin n_bad++; $display("FAIL ab_vals: got cur=%0d best=%0d cnt=%0d want 100/0/0", d_cur, d_best, d_cnt); end
    @(negedge clk); d_abort = 1'b0; d_start = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (d_busy !== 1'b0 || d_cnt !== 0) begin n_bad++; $display("FAIL ab_idle: got busy=%b cnt=%0d want 0/0", d_busy, d_cnt); end
    test_search_37();
  endtask

  initial begin
    d_start = 1'b0; d_abort = 1'b0; d_pass = 1'b0;
    o_start = 1'b0; o_abort = 1'b0; o_pass = 1'b0;
    w_start = 1'b0; w_abort = 1'b0; w_pass = 1'b0;
    test_reset();
    test_search_37();
    test_done_hold();
    test_verify_fail();
    test_all_pass();
    test_single_point();
    test_top_of_range();
    test_reset_midsweep();
    test_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
